// File: rtl/mem_access.sv
// ---------------------------------------------------------------------------
// mem_access -- memory stage of the bexkat1 pipeline
//
// Sits between execute and writeback. Non-memory instructions are forwarded
// to writeback through a single register stage. T_LOAD / T_STORE instructions
// start a Wishbone-classic cycle. Execute is held through stall_o until the
// slave acks. Loads return zero-extended lane data; stores return the
// effective address on result_o.
//
// Optional build macro:
//   MEM_TIMEOUT_EN  when defined, a bus cycle that has waited TIMEOUT_CYCLES
//                   BUS cycles without ack is abandoned. fault_o then pulses
//                   for one cycle and writeback gets a bubble
//                   (reg_write_o = 0). When undefined, the stage waits for ack
//                   indefinitely and fault_o is tied low.
//
// Parameters:
//   TIMEOUT_CYCLES  BUS cycles waited for ack before fault (1..255)
//
// Ports:
//   clk_i, rst_i        clock (rising edge), asynchronous active-high reset
//   ir_i/result_i/reg_data1_i/reg_write_i   registered outputs of execute
//   stall_o             high while a bus cycle is outstanding (state == BUS)
//   ir_o/result_o/reg_write_o               to writeback
//   bus_*               Wishbone-classic master, big-endian byte lanes
//   fault_o             one-cycle pulse on bus timeout
// ---------------------------------------------------------------------------
module mem_access #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [63:0] ir_i,
    input  logic [31:0] result_i,
    input  logic [31:0] reg_data1_i,
    input  logic [1:0]  reg_write_i,
    output logic        stall_o,
    output logic [63:0] ir_o,
    output logic [31:0] result_o,
    output logic [1:0]  reg_write_o,
    output logic        bus_cyc_o,
    output logic        bus_stb_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_adr_o,
    output logic [31:0] bus_dat_o,
    input  logic [31:0] bus_dat_i,
    input  logic        bus_ack_i,
    output logic        fault_o
);

    localparam logic [3:0] T_LOAD  = 4'ha;
    localparam logic [3:0] T_STORE = 4'hb;

    // Out-of-range values are a configuration error. This block only exists
    // so that a bad value is visible in the elaborated hierarchy.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_out_of_range
    end

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUS  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Lane helpers. Byte 0 of a word is the most significant byte, and it
    // is also bit 3 of sel.
    // ------------------------------------------------------------------
    function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] s;
        case (size)
            2'b01:   s = a[1] ? 4'b0011 : 4'b1100;
            2'b10:   s = 4'b1000 >> a;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] r;
        case (size)
            2'b01:   r = {d[15:0], d[15:0]};
            2'b10:   r = {4{d[7:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_data(input logic [1:0] size, input logic [1:0] a,
                                              input logic [31:0] d);
        logic [31:0] r;
        case (size)
            2'b01:   r = a[1] ? {16'h0, d[15:0]} : {16'h0, d[31:16]};
            2'b10: begin
                case (a)
                    2'd0:    r = {24'h0, d[31:24]};
                    2'd1:    r = {24'h0, d[23:16]};
                    2'd2:    r = {24'h0, d[15:8]};
                    default: r = {24'h0, d[7:0]};
                endcase
            end
            default: r = d;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [63:0] ir_q, ir_d;
    logic [31:0] result_q, result_d;
    logic [1:0]  reg_write_q, reg_write_d;

    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] wdat_q, wdat_d;

    // Request captured when the access starts. Execute may change its
    // outputs while stalled, so completion uses only these copies.
    logic [63:0] req_ir_q, req_ir_d;
    logic [1:0]  req_rw_q, req_rw_d;
    logic [31:0] req_addr_q, req_addr_d;

    logic        is_mem;
    logic        req_is_load;

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]  tmo_cnt_q, tmo_cnt_d;
    logic        fault_q, fault_d;
`endif

    assign is_mem      = (ir_i[31:28] == T_LOAD) || (ir_i[31:28] == T_STORE);
    assign req_is_load = (req_ir_q[31:28] == T_LOAD);

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        result_d    = result_q;
        reg_write_d = reg_write_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        wdat_d      = wdat_q;
        req_ir_d    = req_ir_q;
        req_rw_d    = req_rw_q;
        req_addr_d  = req_addr_q;
`ifdef MEM_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        fault_d     = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (is_mem) begin
                    req_ir_d    = ir_i;
                    req_rw_d    = reg_write_i;
                    req_addr_d  = result_i;
                    cyc_d       = 1'b1;
                    we_d        = (ir_i[31:28] == T_STORE);
                    sel_d       = lane_sel(ir_i[25:24], result_i[1:0]);
                    adr_d       = {result_i[31:2], 2'b00};
                    wdat_d      = store_data(ir_i[25:24], reg_data1_i);
                    // Writeback sees a bubble while the access is in flight.
                    ir_d        = 64'h0;
                    result_d    = 32'h0;
                    reg_write_d = 2'b00;
                    state_d     = S_BUS;
`ifdef MEM_TIMEOUT_EN
                    tmo_cnt_d   = 8'h0;
`endif
                end else begin
                    ir_d        = ir_i;
                    result_d    = result_i;
                    reg_write_d = reg_write_i;
                end
            end

            S_BUS: begin
                if (bus_ack_i) begin
                    cyc_d       = 1'b0;
                    we_d        = 1'b0;
                    sel_d       = 4'h0;
                    adr_d       = 32'h0;
                    wdat_d      = 32'h0;
                    ir_d        = req_ir_q;
                    reg_write_d = req_rw_q;
                    result_d    = req_is_load
                                ? load_data(req_ir_q[25:24], req_addr_q[1:0], bus_dat_i)
                                : req_addr_q;
                    state_d     = S_IDLE;
`ifdef MEM_TIMEOUT_EN
                    tmo_cnt_d   = 8'h0;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    // Limit reached without ack: abandon the access and
                    // retire the instruction without a register write.
                    cyc_d       = 1'b0;
                    we_d        = 1'b0;
                    sel_d       = 4'h0;
                    adr_d       = 32'h0;
                    wdat_d      = 32'h0;
                    ir_d        = req_ir_q;
                    reg_write_d = 2'b00;
                    result_d    = 32'h0;
                    fault_d     = 1'b1;
                    tmo_cnt_d   = 8'h0;
                    state_d     = S_IDLE;
                end else begin
                    tmo_cnt_d   = tmo_cnt_q + 8'h1;
`endif
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            ir_q        <= 64'h0;
            result_q    <= 32'h0;
            reg_write_q <= 2'b00;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= 4'h0;
            adr_q       <= 32'h0;
            wdat_q      <= 32'h0;
            req_ir_q    <= 64'h0;
            req_rw_q    <= 2'b00;
            req_addr_q  <= 32'h0;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt_q   <= 8'h0;
            fault_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            result_q    <= result_d;
            reg_write_q <= reg_write_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            wdat_q      <= wdat_d;
            req_ir_q    <= req_ir_d;
            req_rw_q    <= req_rw_d;
            req_addr_q  <= req_addr_d;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            fault_q     <= fault_d;
`endif
        end
    end

    assign stall_o     = (state_q == S_BUS);
    assign ir_o        = ir_q;
    assign result_o    = result_q;
    assign reg_write_o = reg_write_q;
    assign bus_cyc_o   = cyc_q;
    assign bus_stb_o   = cyc_q;
    assign bus_we_o    = we_q;
    assign bus_sel_o   = sel_q;
    assign bus_adr_o   = adr_q;
    assign bus_dat_o   = wdat_q;
`ifdef MEM_TIMEOUT_EN
    assign fault_o     = fault_q;
`else
    assign fault_o     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access.sv
// ---------------------------------------------------------------------------
// tb_mem_access -- self-checking bench for mem_access
//
// Drives and samples on the falling clock edge. Expected values come from a
// byte-oriented reference model: access size in bytes, first byte offset and
// big-endian lane arithmetic. Build with MEM_TIMEOUT_EN defined to cover the
// timeout path; the DUT is instantiated with TIMEOUT_CYCLES = 4.
// ---------------------------------------------------------------------------
module tb_mem_access;

    localparam int TMO  = 4;
    localparam int MAXW = 40;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [63:0] ir_i;
    logic [31:0] result_i;
    logic [31:0] reg_data1_i;
    logic [1:0]  reg_write_i;
    logic        stall_o;
    logic [63:0] ir_o;
    logic [31:0] result_o;
    logic [1:0]  reg_write_o;
    logic        bus_cyc_o, bus_stb_o, bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_adr_o, bus_dat_o;
    logic [31:0] bus_dat_i;
    logic        bus_ack_i;
    logic        fault_o;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ir_i(ir_i), .result_i(result_i), .reg_data1_i(reg_data1_i),
        .reg_write_i(reg_write_i), .stall_o(stall_o),
        .ir_o(ir_o), .result_o(result_o), .reg_write_o(reg_write_o),
        .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o),
        .bus_sel_o(bus_sel_o), .bus_adr_o(bus_adr_o), .bus_dat_o(bus_dat_o),
        .bus_dat_i(bus_dat_i), .bus_ack_i(bus_ack_i), .fault_o(fault_o)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [1:0] sz);
        if (sz == 2'b01) return 2;
        if (sz == 2'b10) return 1;
        return 4;
    endfunction

    function automatic int first_byte(input logic [1:0] sz, input logic [31:0] a);
        int n = nbytes(sz);
        return (int'(a[1:0]) / n) * n;
    endfunction

    function automatic logic [3:0] model_sel(input logic [1:0] sz, input logic [31:0] a);
        logic [3:0] s = 4'h0;
        int f = first_byte(sz, a);
        for (int k = f; k < f + nbytes(sz); k++) s[3-k] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic [31:0] a,
                                               input logic [31:0] d);
        int n = nbytes(sz);
        int f = first_byte(sz, a);
        longint unsigned mask = (64'd1 << (8 * n)) - 1;
        return 32'((longint'(d) >> (8 * (4 - f - n))) & mask);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] d);
        int n = nbytes(sz);
        longint unsigned low = longint'(d) & ((64'd1 << (8 * n)) - 1);
        longint unsigned rep = 0;
        for (int i = 0; i < 4 / n; i++) rep = (rep << (8 * n)) | low;
        return 32'(rep);
    endfunction

    function automatic logic [63:0] rand_alu_ir();
        logic [3:0] t;
        do t = 4'($urandom_range(0, 15)); while (t == 4'ha || t == 4'hb);
        return {32'($urandom), t, 28'($urandom)};
    endfunction

    // ---------------- transaction driver (no checking) ----------------
    typedef struct {
        logic [63:0] ir_in;
        logic [3:0]  sel;
        logic [31:0] adr, dat;
        logic        we, cyc, stb;
        int          stalls;
        bit          stable;
        bit          fault_seen;
        logic [31:0] result;
        logic [63:0] ir_out;
        logic [1:0]  rw;
        logic        cyc_after, fault;
    } obs_t;

    // Called just after a falling edge with the DUT idle. waits < 0 = never ack.
    task automatic run_mem(input bit st, input logic [1:0] sz, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd, input int waits,
                           input logic [1:0] rw, input logic [63:0] stall_ir, output obs_t o);
        o.ir_in = {32'($urandom), (st ? 4'hb : 4'ha), 2'($urandom), sz, 24'($urandom)};
        ir_i = o.ir_in; result_i = addr; reg_data1_i = wd; reg_write_i = rw;
        @(negedge clk_i);
        o.sel = bus_sel_o; o.adr = bus_adr_o; o.dat = bus_dat_o;
        o.we = bus_we_o; o.cyc = bus_cyc_o; o.stb = bus_stb_o;
        o.stable = 1; o.fault_seen = 0; o.stalls = 0;
        ir_i = stall_ir; result_i = $urandom; reg_data1_i = $urandom; reg_write_i = 2'($urandom);
        for (int c = 0; c < MAXW && stall_o; c++) begin
            o.stalls++;
            if ({bus_sel_o, bus_adr_o, bus_dat_o, bus_we_o, bus_cyc_o} !==
                {o.sel, o.adr, o.dat, o.we, o.cyc}) o.stable = 0;
            if (fault_o) o.fault_seen = 1;
            bus_ack_i = (c == waits);
            bus_dat_i = (c == waits) ? rd : $urandom;
            @(negedge clk_i);
            bus_ack_i = 1'b0;
        end
        o.result = result_o; o.ir_out = ir_o; o.rw = reg_write_o;
        o.cyc_after = bus_cyc_o; o.fault = fault_o;
        ir_i = 64'h0; reg_write_i = 2'b00;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_i = 1'b1; ir_i = 64'h0; result_i = 0; reg_data1_i = 0; reg_write_i = 0;
        bus_dat_i = 0; bus_ack_i = 0;
        repeat (2) @(negedge clk_i);
        n_checks++;
        if ({ir_o, result_o, reg_write_o} !== 98'h0) begin
            n_fail++; $display("FAIL reset_wb: got ir=%h res=%h rw=%0d expected all zero", ir_o, result_o, reg_write_o);
        end
        n_checks++;
        if ({bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, bus_adr_o, bus_dat_o, fault_o, stall_o} !== 74'h0) begin
            n_fail++; $display("FAIL reset_bus: got cyc=%b sel=%h adr=%h dat=%h fault=%b stall=%b expected all zero",
                               bus_cyc_o, bus_sel_o, bus_adr_o, bus_dat_o, fault_o, stall_o);
        end
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_alu();
        logic [63:0] ir;
        ir = {32'h0, 4'h4, 28'h0};
        ir_i = ir; result_i = 32'h1234; reg_write_i = 2'd1;
        @(negedge clk_i);
        n_checks++;
        if ({result_o, reg_write_o, ir_o, bus_cyc_o, stall_o} !== {32'h1234, 2'd1, ir, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL alu_directed: got res=%h rw=%0d cyc=%b stall=%b expected res=1234 rw=1 cyc=0 stall=0",
                               result_o, reg_write_o, bus_cyc_o, stall_o);
        end
        for (int i = 0; i < 10; i++) begin
            logic [31:0] r;
            logic [1:0]  w;
            ir = rand_alu_ir(); r = $urandom; w = 2'($urandom);
            ir_i = ir; result_i = r; reg_write_i = w;
            @(negedge clk_i);
            n_checks++;
            if ({ir_o, result_o, reg_write_o, bus_cyc_o, stall_o} !== {ir, r, w, 1'b0, 1'b0}) begin
                n_fail++; $display("FAIL alu_random[%0d]: got ir=%h res=%h rw=%0d cyc=%b expected ir=%h res=%h rw=%0d cyc=0",
                                   i, ir_o, result_o, reg_write_o, bus_cyc_o, ir, r, w);
            end
        end
        ir_i = 64'h0; reg_write_i = 0;
    endtask

    task automatic test_word_load();
        obs_t o;
        run_mem(1'b0, 2'b00, 32'h100, $urandom, 32'hcafef00d, 3, 2'd1, 64'h0, o);
        n_checks++;
        if (o.stalls !== 4) begin n_fail++; $display("FAIL wload_stall: got %0d cycles expected 4", o.stalls); end
        n_checks++;
        if ({o.cyc, o.stb, o.we, o.sel, o.adr} !== {1'b1, 1'b1, 1'b0, 4'hf, 32'h100}) begin
            n_fail++; $display("FAIL wload_bus: got cyc=%b stb=%b we=%b sel=%h adr=%h expected 1 1 0 f 00000100",
                               o.cyc, o.stb, o.we, o.sel, o.adr);
        end
        n_checks++;
        if ({o.result, o.rw, o.ir_out, o.cyc_after} !== {32'hcafef00d, 2'd1, o.ir_in, 1'b0}) begin
            n_fail++; $display("FAIL wload_wb: got res=%h rw=%0d cyc_after=%b expected res=cafef00d rw=1 cyc_after=0",
                               o.result, o.rw, o.cyc_after);
        end
    endtask

    task automatic test_byte_store();
        obs_t o;
        run_mem(1'b1, 2'b10, 32'h203, 32'h1234565a, $urandom, 1, 2'd0, 64'h0, o);
        n_checks++;
        if ({o.adr, o.sel, o.dat, o.we} !== {32'h200, 4'b0001, 32'h5a5a5a5a, 1'b1}) begin
            n_fail++; $display("FAIL bstore_bus: got adr=%h sel=%b dat=%h we=%b expected 00000200 0001 5a5a5a5a 1",
                               o.adr, o.sel, o.dat, o.we);
        end
        n_checks++;
        if ({o.result, o.rw, o.ir_out, o.stalls} !== {32'h203, 2'd0, o.ir_in, 32'd2}) begin
            n_fail++; $display("FAIL bstore_wb: got res=%h rw=%0d stalls=%0d expected res=00000203 rw=0 stalls=2",
                               o.result, o.rw, o.stalls);
        end
    endtask

    task automatic test_half_load();
        obs_t o;
        run_mem(1'b0, 2'b01, 32'h302, $urandom, 32'h1111beef, 0, 2'd2, 64'h0, o);
        n_checks++;
        if ({o.sel, o.adr, o.stalls} !== {4'b0011, 32'h300, 32'd1}) begin
            n_fail++; $display("FAIL hload_bus: got sel=%b adr=%h stalls=%0d expected 0011 00000300 1", o.sel, o.adr, o.stalls);
        end
        n_checks++;
        if ({o.result, o.rw} !== {32'h0000beef, 2'd2}) begin
            n_fail++; $display("FAIL hload_wb: got res=%h rw=%0d expected 0000beef 2", o.result, o.rw);
        end
    endtask

    task automatic test_random_mem();
        for (int i = 0; i < 40; i++) begin
            obs_t o;
            bit st = 1'($urandom);
            logic [1:0]  sz = 2'($urandom);
            logic [31:0] a = $urandom, wd = $urandom, rd = $urandom;
            int w = $urandom_range(0, TMO - 1);
            logic [1:0]  rw = 2'($urandom);
            logic [63:0] sir = (i % 2 == 1) ? {32'($urandom), 4'ha, 28'($urandom)} : rand_alu_ir();
            logic [31:0] exp_res = st ? a : model_load(sz, a, rd);
            run_mem(st, sz, a, wd, rd, w, rw, sir, o);
            n_checks++;
            if ({o.sel, o.adr, o.we, o.cyc, o.stb} !== {model_sel(sz, a), a & 32'hffff_fffc, st, 1'b1, 1'b1}) begin
                n_fail++; $display("FAIL rand_req[%0d]: got sel=%b adr=%h we=%b cyc=%b expected sel=%b adr=%h we=%b cyc=1",
                                   i, o.sel, o.adr, o.we, o.cyc, model_sel(sz, a), a & 32'hffff_fffc, st);
            end
            if (st) begin
                n_checks++;
                if (o.dat !== model_wdata(sz, wd)) begin
                    n_fail++; $display("FAIL rand_wdat[%0d]: got %h expected %h (sz=%0d)", i, o.dat, model_wdata(sz, wd), sz);
                end
            end
            n_checks++;
            if (o.stalls !== w + 1 || !o.stable) begin
                n_fail++; $display("FAIL rand_hold[%0d]: got stalls=%0d stable=%0d expected stalls=%0d stable=1",
                                   i, o.stalls, o.stable, w + 1);
            end
            n_checks++;
            if ({o.result, o.rw, o.ir_out, o.cyc_after} !== {exp_res, rw, o.ir_in, 1'b0}) begin
                n_fail++; $display("FAIL rand_wb[%0d]: got res=%h rw=%0d ir=%h cyc_after=%b expected res=%h rw=%0d ir=%h cyc_after=0",
                                   i, o.result, o.rw, o.ir_out, o.cyc_after, exp_res, rw, o.ir_in);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            obs_t o;
            logic [63:0] ir = rand_alu_ir();
            logic [31:0] r = $urandom, d = $urandom;
            run_mem(1'b0, 2'b00, 32'h40 + 32'(i * 4), $urandom, d, i % TMO, 2'd1, rand_alu_ir(), o);
            n_checks++;
            if (o.result !== d) begin n_fail++; $display("FAIL b2b_load[%0d]: got %h expected %h", i, o.result, d); end
            ir_i = ir; result_i = r; reg_write_i = 2'd3;
            @(negedge clk_i);
            n_checks++;
            if ({ir_o, result_o, reg_write_o, stall_o} !== {ir, r, 2'd3, 1'b0}) begin
                n_fail++; $display("FAIL b2b_alu[%0d]: got ir=%h res=%h rw=%0d stall=%b expected ir=%h res=%h rw=3 stall=0",
                                   i, ir_o, result_o, reg_write_o, stall_o, ir, r);
            end
        end
        ir_i = 64'h0; reg_write_i = 0;
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        obs_t o;
        run_mem(1'b0, 2'b00, 32'h500, $urandom, $urandom, -1, 2'd1, 64'h0, o);
        n_checks++;
        if ({o.stalls, o.cyc_after, o.fault, o.fault_seen} !== {TMO, 1'b0, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL timeout_bus: got stalls=%0d cyc_after=%b fault=%b early_fault=%b expected %0d 0 1 0",
                               o.stalls, o.cyc_after, o.fault, o.fault_seen, TMO);
        end
        n_checks++;
        if ({o.rw, o.result, o.ir_out} !== {2'd0, 32'h0, o.ir_in}) begin
            n_fail++; $display("FAIL timeout_wb: got rw=%0d res=%h ir=%h expected rw=0 res=0 ir=%h", o.rw, o.result, o.ir_out, o.ir_in);
        end
        @(negedge clk_i);
        n_checks++;
        if (fault_o !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse: got fault=%b expected 0 after one cycle", fault_o); end
        run_mem(1'b0, 2'b00, 32'h504, $urandom, 32'h600d600d, TMO - 1, 2'd1, 64'h0, o);
        n_checks++;
        if ({o.fault, o.fault_seen, o.result, o.rw} !== {1'b0, 1'b0, 32'h600d600d, 2'd1}) begin
            n_fail++; $display("FAIL timeout_ack_wins: got fault=%b res=%h rw=%0d expected fault=0 res=600d600d rw=1",
                               o.fault, o.result, o.rw);
        end
    endtask
`else
    task automatic test_long_wait();
        obs_t o;
        run_mem(1'b0, 2'b10, 32'h701, $urandom, 32'h00ab0000, 20, 2'd1, 64'h0, o);
        n_checks++;
        if ({o.stalls, o.fault_seen, o.fault, o.result} !== {32'd21, 1'b0, 1'b0, 32'h000000ab}) begin
            n_fail++; $display("FAIL long_wait: got stalls=%0d fault=%b res=%h expected 21 0 000000ab",
                               o.stalls, o.fault_seen | o.fault, o.result);
        end
    endtask
`endif

    task automatic test_reset_mid();
        logic [63:0] ir;
        ir_i = {32'h0, 4'ha, 28'h0}; result_i = 32'h900; reg_write_i = 2'd1;
        @(negedge clk_i);
        ir_i = 64'h0; reg_write_i = 0;
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        n_checks++;
        if ({bus_cyc_o, bus_stb_o, stall_o} !== 3'b000) begin
            n_fail++; $display("FAIL reset_mid: got cyc=%b stb=%b stall=%b expected 0 0 0", bus_cyc_o, bus_stb_o, stall_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        ir = rand_alu_ir();
        ir_i = ir; result_i = 32'hfeed0001; reg_write_i = 2'd1;
        @(negedge clk_i);
        n_checks++;
        if ({ir_o, result_o, reg_write_o, bus_cyc_o} !== {ir, 32'hfeed0001, 2'd1, 1'b0}) begin
            n_fail++; $display("FAIL reset_recover: got res=%h rw=%0d cyc=%b expected feed0001 1 0", result_o, reg_write_o, bus_cyc_o);
        end
        ir_i = 64'h0; reg_write_i = 0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_word_load();
        test_byte_store();
        test_half_load();
        test_random_mem();
        test_back_to_back();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
